// File: rtl/md_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and operand-signedness helpers.
package md_unit_pkg;

  // RISC-V M-extension op codes; op[2] set means a divide-family op.
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM (not MULHSU).
  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/md_iter_step.sv
// One iteration of the multiply/divide datapath on a 2*WIDTH accumulator.
// Multiply: acc = {partial_high, remaining multiplier bits}; add-then-shift-right.
// Divide:   acc = {partial remainder, remaining dividend/quotient bits};
//           shift-left, trial subtract, shift in the quotient bit.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   sh_hi;
  logic             ge;
  logic [WIDTH-1:0] diff;

  // Shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    sh_hi = acc[2*WIDTH-1:WIDTH-1];
    ge    = sh_hi >= {1'b0, operand};
    // When ge holds the difference is below the divisor, so WIDTH bits suffice.
    diff  = sh_hi[WIDTH-1:0] - operand;
    if (!is_div) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else if (ge) begin
      acc_next = {diff, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sh_hi[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready on
// both sides. Works on magnitudes and fixes the sign in a final FIX cycle.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             negative
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_reg, state_next;
  logic [2:0]           op_reg;
  logic                 sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0]     operand_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [WIDTH-1:0]     res_reg;

  logic                 neg_a, neg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic                 div_zero, div_ovf, special;
  logic [WIDTH-1:0]     special_res;
  logic                 accept;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo, rem, fix_res;

  // Operand magnitudes, signs and the divide special cases seen at accept time.
  always_comb begin
    neg_a       = op_signed_a(op) & a[WIDTH-1];
    neg_b       = op_signed_b(op) & b[WIDTH-1];
    mag_a       = neg_a ? -a : a;
    mag_b       = neg_b ? -b : b;
    div_zero    = op[2] && (b == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == '1);
    special     = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) special_res = op[1] ? a : '1;
    else          special_res = op[1] ? '0 : a;
    accept      = in_valid && (state_reg == ST_IDLE) && !flush;
  end

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_reg[2]),
    .acc      (acc_reg),
    .operand  (operand_reg),
    .acc_next (acc_step)
  );

  // Sign correction and result-half selection used in FIX.
  always_comb begin
    prod = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
    quo  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    rem  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    case (op_reg)
      OP_MUL:                      fix_res = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             fix_res = quo;
      default:                     fix_res = rem;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_reg == '0) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: if (out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush) state_next = ST_IDLE;
  end

  // Datapath: load on accept, iterate in CALC, write the result in FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg      <= '0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      operand_reg <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      res_reg     <= '0;
    end else if (accept) begin
      op_reg      <= op;
      sign_a_reg  <= neg_a;
      sign_b_reg  <= neg_b;
      operand_reg <= op[2] ? mag_b : mag_a;
      acc_reg     <= {{WIDTH{1'b0}}, (op[2] ? mag_a : mag_b)};
      cnt_reg     <= CNT_W'(WIDTH - 1);
      if (special) res_reg <= special_res;
    end else if (!flush && state_reg == ST_CALC) begin
      acc_reg <= acc_step;
      if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
    end else if (!flush && state_reg == ST_FIX) begin
      res_reg <= fix_res;
    end
  end

  assign in_ready  = (state_reg == ST_IDLE);
  assign out_valid = (state_reg == ST_DONE);
  assign res       = res_reg;
  assign zero      = (res_reg == '0);
  assign negative  = res_reg[WIDTH-1];

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table, randomized ops
// against a 64-bit arithmetic reference, and handshake/flush/reset sequences.
module tb_md_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, zero, negative;
  logic [W-1:0]  res;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .negative  (negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    int           exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: RISC-V M semantics computed with 64-bit integer arithmetic.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    longint          sx, sy, p;
    longint unsigned ux, uy, up;
    logic [W-1:0]    r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = '0;
    case (o)
      3'd0: begin p = sx * sy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * longint'(uy); r = p[63:32]; end
      3'd3: begin up = ux * uy; r = up[63:32]; end
      3'd4: if (y == 0) r = '1; else begin p = sx / sy; r = p[31:0]; end
      3'd5: if (y == 0) r = '1; else begin up = ux / uy; r = up[31:0]; end
      3'd6: if (y == 0) r = x;  else begin p = sx % sy; r = p[31:0]; end
      default: if (y == 0) r = x; else begin up = ux % uy; r = up[31:0]; end
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return LAT;
  endfunction

  // Issue one op, wait (bounded) for out_valid, hold for 'hold' cycles, then handshake.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold, output logic [W-1:0] r, output int lat,
                        output logic z, output logic ng);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    r = res; z = zero; ng = negative;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_res", 64'(res), 64'(r));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ready_after_handshake", 64'(in_ready), 64'd1);
    check("valid_after_handshake", 64'(out_valid), 64'd0);
    $display("op=%0d a=%h b=%h res=%h lat=%0d zero=%0b neg=%0b", o, x, y, r, lat, z, ng);
  endtask

  task automatic check_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] exp_r, input int exp_l);
    logic [W-1:0] r;
    int           l;
    logic         z, ng;
    run_op(o, x, y, 0, r, l, z, ng);
    check({tag, "_res"}, 64'(r), 64'(exp_r));
    check({tag, "_lat"}, 64'(l), 64'(exp_l));
    check({tag, "_zero"}, 64'(z), 64'(exp_r == '0));
    check({tag, "_neg"}, 64'(ng), 64'(exp_r[W-1]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_res"}, 64'(res), 64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd1);
    check({tag, "_negative"}, 64'(negative), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] r, ra, rb;
    logic [2:0]   ro;
    int           l;
    logic         z, ng, seen;

    vecs = '{
      '{3'd0, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFEB, LAT},
      '{3'd1, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, LAT},
      '{3'd3, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, LAT},
      '{3'd2, 32'hFFFF_FFFF, 32'd2,          32'hFFFF_FFFF, LAT},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, LAT},
      '{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, LAT},
      '{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, LAT},
      '{3'd6, 32'd7,         32'hFFFF_FFFE,  32'd1,         LAT},
      '{3'd5, 32'd5,         32'd0,          32'hFFFF_FFFF, 1},
      '{3'd7, 32'd5,         32'd0,          32'd5,         1},
      '{3'd4, 32'd5,         32'd0,          32'hFFFF_FFFF, 1},
      '{3'd6, 32'hFFFF_FFFD, 32'd0,          32'hFFFF_FFFD, 1},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 1},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         1},
      '{3'd4, 32'h8000_0000, 32'd1,          32'h8000_0000, LAT},
      '{3'd5, 32'hFFFF_FFFF, 32'd1,          32'hFFFF_FFFF, LAT}
    };

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    foreach (vecs[i]) begin
      check_op("vec", vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);
    end

    // Result held stable while the consumer stalls.
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 5, r, l, z, ng);
    check("hold_final_res", 64'(r), 64'h0000_0000_FFFF_FFEB);

    // Randomized ops against the reference.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: begin ra = $urandom; rb = '0; end
        1: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom; end
        2: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(1, 9)); end
        3: begin ra = -32'($urandom_range(0, 50)); rb = -32'($urandom_range(1, 9)); end
        default: begin ra = $urandom; rb = $urandom; end
      endcase
      check_op("rand", ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb));
    end

    // Flush in cycle T+10: operation dropped, out_valid never seen.
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    $display("flush sequence: out_valid seen=%0b", seen);

    // Flush together with in_valid in IDLE: not accepted.
    @(negedge clk);
    op = 3'd5; a = 32'd9; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_in_ready", 64'(in_ready), 64'd1);
    check("flush_idle_out_valid", 64'(out_valid), 64'd0);
    $display("flush+in_valid in IDLE: in_ready=%0b out_valid=%0b", in_ready, out_valid);

    // Unit still works after a flush.
    check_op("post_flush", 3'd4, 32'd1000, 32'd7, 32'd142, LAT);

    // Asynchronous reset at T+5 with a nonzero previous result.
    check_op("pre_reset", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT);
    @(negedge clk);
    op = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    $display("async reset mid-op: in_ready=%0b out_valid=%0b res=%h", in_ready, out_valid, res);
    @(negedge clk);
    rst_n = 1'b1;

    check_op("post_reset", 3'd7, 32'd100, 32'd7, 32'd2, LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit for the pipeline's execute stage. It extends the single-cycle ALU with the RISC-V M-extension operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The datapath width is parametrised, and the unit uses a valid/ready handshake on both sides. The hazard unit stalls on `in_ready`/`out_valid`, and `flush` aborts a speculative operation on branch mispredict.

## Interface
- `WIDTH`, default 32: operand and result width, minimum 4, even.
- `CNT_W`, default `$clog2(WIDTH)+1`: iteration counter width.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and op are valid.
- `in_ready`  out  1  unit can accept an operation.
- `op`  in  3  operation code, encoded in the shared header.
- `a`  in  WIDTH  dividend or multiplicand (rs1).
- `b`  in  WIDTH  divisor or multiplier (rs2).
- `flush`  in  1  abort the current operation; highest priority after reset.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `res`  out  WIDTH  result.
- `zero`  out  1  `res == 0`.
- `negative`  out  1  `res[WIDTH-1]`.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **IDLE:** `in_ready=1`. On `in_valid`, latch `op`, `|a|`, `|b|` and the sign of each operand.
  - Operands are treated as signed for MUL/MULH/DIV/REM.
  - For MULHSU, only `a` is signed.
- **Special cases (IDLE→DONE directly):**
  - Division by zero: DIV/DIVU return all-ones; REM/REMU return `a`.
  - Signed overflow (`a` = most-negative value, `b` = -1): DIV returns `a`; REM returns 0.
- **Otherwise IDLE→CALC.** The counter loads `WIDTH-1`.
- **CALC, multiply:** shift-add over a 2·WIDTH accumulator, one multiplier bit per cycle.
- **CALC, divide:** restoring shift-subtract, one quotient bit per cycle.
- **CALC exit:** move to FIX when the counter is 0 at the end of a cycle.
- **FIX:** apply the sign correction.
  - Product: negate the 2·WIDTH product if `sign_a ^ sign_b` (MULHSU uses `sign_a` only).
  - Quotient: negate if the operand signs differ.
  - Remainder: takes the sign of the dividend.
  - Select the result half: MUL gives the low WIDTH bits; MULH/MULHSU/MULHU give the high WIDTH bits.
  - Then move to DONE.
- **DONE:** `out_valid=1` and `res` is held stable until `out_ready`. On `out_ready`, return to IDLE.
- **`flush`:** from any state, go to IDLE next cycle. Any pending result is dropped and `out_valid` is 0 next cycle.
- **`flush` in IDLE:** `flush` together with `in_valid` means the operation is not accepted.
- **`zero`/`negative`:** combinational from `res`. They are valid only while `out_valid=1`.
- **Arithmetic:** unsigned magnitudes throughout. Negation is two's complement modulo 2^WIDTH (or 2^(2·WIDTH) for the product).

## Timing
- **Reset values:** state=IDLE, `in_ready=1`, `out_valid=0`, `res=0`, `zero=1`, `negative=0`. All internal registers are 0.
- **Normal path:** accept in cycle T; CALC spans T+1 … T+WIDTH; FIX at T+WIDTH+1; `out_valid` rises at T+WIDTH+2.
- **Special cases:** `out_valid` rises at T+1.
- **Throughput:** at most one operation in flight. `in_ready=0` in CALC, FIX and DONE.
- **Back-to-back:** DONE→IDLE takes one cycle, so the next accept is no earlier than the cycle after the result handshake. There is no same-cycle re-accept.
- **Handshake rule:** `res` must not change while `out_valid=1` and `out_ready=0`.
- **Reset mid-operation:** asynchronous. Outputs take their reset values immediately, with no partial result.

## Structure
- **Shared header `MdOp.vh`:**
  - Op localparams: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - `op[2]` distinguishes divide from multiply.
  - State encodings.
- **Sub-module `md_iter_step`:** combinational, parametrised by WIDTH. It performs one shift-add step or one shift-subtract step, selected by a `is_div` input.
- **Top level:** contains the FSM, counter, sign logic, special-case detection and the FIX negation.

## Test plan
- **MUL/MULH:** `a=-3`, `b=7` → MUL `res=0xFFFFFFEB`; MULH `res=0xFFFFFFFF`; `out_valid` at T+34.
- **MULHU/MULHSU:** `a=0xFFFFFFFF`, `b=2` → MULHU `res=1`; MULHSU `res=0xFFFFFFFF`.
- **DIV/REM:** `a=-7`, `b=2` → DIV `res=0xFFFFFFFD`; REM `res=0xFFFFFFFF`, `negative=1`.
- **DIVU by zero:** `b=0`, `a=5` → DIVU `res=0xFFFFFFFF` at T+1; REMU `res=5`.
- **DIV overflow:** `a=0x80000000`, `b=-1` → DIV `res=0x80000000` at T+1; REM `res=0`, `zero=1`.
- **Control:**
  - Hold `out_ready=0` for 5 cycles → `res` stable throughout.
  - `flush` at T+10 → IDLE, with `out_valid` never asserted.
  - `rst_n` low at T+5 → outputs at reset values immediately.
